// File: rtl/execute_if.sv
// execute_if: ID_EX inputs, writeback forwarding bus, EX_MEM outputs and
// the stall handshake of the MIPS execute stage. "master" is the pipeline
// around the stage, "slave" is the execute stage itself.
interface execute_if;
  logic        mem_stall_c;
  logic [31:0] ID_EX_nextPC;
  logic [31:0] ID_EX_A;
  logic [31:0] ID_EX_B;
  logic [15:0] ID_EX_imm;
  logic [4:0]  ID_EX_rs;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;
  logic [5:0]  ID_EX_op;
  logic [1:0]  ID_EX_instruc_type;
  logic        WB_WEenable;
  logic [4:0]  WB_dest;
  logic [31:0] WB_value;
  logic [31:0] EX_MEM_nextPC;
  logic [31:0] EX_MEM_ALUout;
  logic [31:0] EX_MEM_B;
  logic [4:0]  EX_MEM_dest;
  logic        EX_MEM_regwrite;
  logic [5:0]  EX_MEM_op;
  logic [1:0]  EX_MEM_instruc_type;
  logic        EX_MEM_changePC_c;
  logic [31:0] EX_MEM_target;
  logic        ex_stall_c;

  modport master (
    output mem_stall_c, ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
           ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type,
           WB_WEenable, WB_dest, WB_value,
    input  EX_MEM_nextPC, EX_MEM_ALUout, EX_MEM_B, EX_MEM_dest,
           EX_MEM_regwrite, EX_MEM_op, EX_MEM_instruc_type,
           EX_MEM_changePC_c, EX_MEM_target, ex_stall_c
  );

  modport slave (
    input  mem_stall_c, ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
           ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type,
           WB_WEenable, WB_dest, WB_value,
    output EX_MEM_nextPC, EX_MEM_ALUout, EX_MEM_B, EX_MEM_dest,
           EX_MEM_regwrite, EX_MEM_op, EX_MEM_instruc_type,
           EX_MEM_changePC_c, EX_MEM_target, ex_stall_c
  );
endinterface

// File: rtl/execute.sv
// execute: EX stage of the 5-stage MIPS pipeline. Single-cycle ALU ops,
// branch/jump resolution with a one-cycle redirect pulse, and a 32-iteration
// signed MULT/DIV unit (magnitude shift-add / restoring divide) writing HI/LO.
// Build option: define EX_FORWARD_EN to forward EX_MEM / WB results into A/B.
module execute #(
  parameter logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic     clock,
  input  logic     reset_n,
  execute_if.slave bus
);
  localparam logic [1:0] T_J = 2'b01, T_I = 2'b10, T_R = 2'b11;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000,
                         F_MULT = 6'b011000, F_DIV = 6'b011010,
                         F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] O_ADDI = 6'b001000, O_SLTI = 6'b001010, O_ANDI = 6'b001100,
                         O_ORI = 6'b001101, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101, O_J = 6'b000010;
  localparam logic [1:0] S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10;

  // EX_MEM pipeline register
  logic [31:0] npc_q, alu_q, b_q, tgt_q;
  logic [4:0]  dest_q;
  logic        wr_q, chg_q;
  logic [5:0]  op_q;
  logic [1:0]  ty_q;

  // HI/LO and the iterative multiply/divide datapath
  logic [31:0] hi_q, lo_q, dsr_q, araw_q;
  logic [1:0]  st_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic        div_q, sa_q, sb_q, bz_q;

  logic [31:0] a_fwd, b_fwd;

`ifdef EX_FORWARD_EN
  logic exm_ok;
  // A load's EX_MEM value is an address, not data: never forward it
  assign exm_ok = wr_q && !(ty_q == T_I && op_q == O_LW);

  // Operand bypass: youngest producer (EX_MEM) beats WB, r0 is never bypassed
  always_comb begin
    a_fwd = bus.ID_EX_A;
    b_fwd = bus.ID_EX_B;
    if (bus.ID_EX_rs != 5'd0 && exm_ok && dest_q == bus.ID_EX_rs)
      a_fwd = alu_q;
    else if (bus.ID_EX_rs != 5'd0 && bus.WB_WEenable && bus.WB_dest == bus.ID_EX_rs)
      a_fwd = bus.WB_value;
    if (bus.ID_EX_rt != 5'd0 && exm_ok && dest_q == bus.ID_EX_rt)
      b_fwd = alu_q;
    else if (bus.ID_EX_rt != 5'd0 && bus.WB_WEenable && bus.WB_dest == bus.ID_EX_rt)
      b_fwd = bus.WB_value;
  end
`else
  logic unused_ok;
  assign a_fwd = bus.ID_EX_A;
  assign b_fwd = bus.ID_EX_B;
  assign unused_ok = ^{bus.WB_WEenable, bus.WB_dest, bus.WB_value};
`endif

  logic [31:0] sx, res, tgt;
  logic [4:0]  dst;
  logic        vld, wr, tkn, is_md, md_go;
  assign sx = {{16{bus.ID_EX_imm[15]}}, bus.ID_EX_imm};

  // Decode + single-cycle ALU; vld=0 means the slot becomes a bubble
  always_comb begin
    vld = 1'b0; wr = 1'b0; tkn = 1'b0; is_md = 1'b0;
    dst = 5'd0; res = 32'd0; tgt = 32'd0;
    case (bus.ID_EX_instruc_type)
      T_R: begin
        vld = 1'b1; wr = 1'b1; dst = bus.ID_EX_rd;
        case (bus.ID_EX_op)
          F_ADD:  res = a_fwd + b_fwd;
          F_SUB:  res = a_fwd - b_fwd;
          F_AND:  res = a_fwd & b_fwd;
          F_OR:   res = a_fwd | b_fwd;
          F_SLT:  res = {31'd0, $signed(a_fwd) < $signed(b_fwd)};
          F_SLL:  res = b_fwd << bus.ID_EX_imm[10:6];
          F_MFHI: res = hi_q;
          F_MFLO: res = lo_q;
          F_MULT, F_DIV: begin is_md = 1'b1; vld = 1'b0; wr = 1'b0; end
          default: begin vld = 1'b0; wr = 1'b0; end
        endcase
      end
      T_I: begin
        vld = 1'b1; wr = 1'b1; dst = bus.ID_EX_rt;
        case (bus.ID_EX_op)
          O_ADDI: res = a_fwd + sx;
          O_SLTI: res = {31'd0, $signed(a_fwd) < $signed(sx)};
          O_ANDI: res = a_fwd & {16'd0, bus.ID_EX_imm};
          O_ORI:  res = a_fwd | {16'd0, bus.ID_EX_imm};
          O_LW:   res = a_fwd + sx;
          O_SW:   begin res = a_fwd + sx; wr = 1'b0; end
          O_BEQ:  begin wr = 1'b0; tkn = (a_fwd == b_fwd); end
          O_BNE:  begin wr = 1'b0; tkn = (a_fwd != b_fwd); end
          default: begin vld = 1'b0; wr = 1'b0; end
        endcase
        if (tkn) tgt = bus.ID_EX_nextPC + (sx << 2);
      end
      T_J: begin
        if (bus.ID_EX_op == O_J) begin
          vld = 1'b1; tkn = 1'b1;
          tgt = {bus.ID_EX_nextPC[31:28], bus.ID_EX_rs, bus.ID_EX_rt,
                 bus.ID_EX_imm, 2'b00};
        end
      end
      default: ;
    endcase
  end

  // A MULT/DIV sitting in the squash shadow of a redirect must neither launch
  // nor stall, so the flush can replace it
  assign md_go = is_md && !chg_q;
  assign bus.ex_stall_c = md_go && (st_q != S_DONE);

  logic [31:0] mag_a, mag_b;
  logic [32:0] msum, dsh, ddif;
  logic [63:0] acc_step, prod;
  logic [31:0] hi_d, lo_d;
  assign mag_a = a_fwd[31] ? -a_fwd : a_fwd;
  assign mag_b = b_fwd[31] ? -b_fwd : b_fwd;

  // One iteration: multiply adds multiplicand to the high half and shifts right;
  // divide shifts {rem,quo} left and subtracts the divisor when it fits
  always_comb begin
    msum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dsr_q} : 33'd0);
    dsh  = acc_q[63:31];
    ddif = dsh - {1'b0, dsr_q};
    if (div_q)
      acc_step = (dsh >= {1'b0, dsr_q}) ? {ddif[31:0], acc_q[30:0], 1'b1}
                                        : {dsh[31:0], acc_q[30:0], 1'b0};
    else
      acc_step = {msum, acc_q[31:1]};
  end

  // Sign correction of the magnitude result and the divide special cases
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    hi_d = prod[63:32];
    lo_d = prod[31:0];
    if (div_q) begin
      if (bz_q) begin
        hi_d = araw_q;
        lo_d = DIV_BY_ZERO_LO;
      end else begin
        lo_d = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
        hi_d = sa_q ? -acc_q[63:32] : acc_q[63:32];
      end
    end
  end

  // MULT/DIV sequencer: IDLE launch, 32 BUSY iterations, DONE commits HI/LO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= S_IDLE; cnt_q <= 5'd0; acc_q <= 64'd0; dsr_q <= 32'd0;
      araw_q <= 32'd0; div_q <= 1'b0; sa_q <= 1'b0; sb_q <= 1'b0; bz_q <= 1'b0;
      hi_q <= 32'd0; lo_q <= 32'd0;
    end else begin
      case (st_q)
        S_IDLE: if (md_go) begin
          st_q   <= S_BUSY;
          cnt_q  <= 5'd0;
          div_q  <= (bus.ID_EX_op == F_DIV);
          sa_q   <= a_fwd[31];
          sb_q   <= b_fwd[31];
          bz_q   <= (b_fwd == 32'd0);
          araw_q <= a_fwd;
          acc_q  <= {32'd0, (bus.ID_EX_op == F_DIV) ? mag_a : mag_b};
          dsr_q  <= (bus.ID_EX_op == F_DIV) ? mag_b : mag_a;
        end
        S_BUSY: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) st_q <= S_DONE;
        end
        S_DONE: if (!bus.mem_stall_c) begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  // EX_MEM register: hold on mem stall (redirect still drops), squash after a
  // redirect, bubble for MULT/DIV and unknown ops, else capture the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      npc_q <= 32'd0; alu_q <= 32'd0; b_q <= 32'd0; tgt_q <= 32'd0;
      dest_q <= 5'd0; wr_q <= 1'b0; chg_q <= 1'b0; op_q <= 6'd0; ty_q <= 2'd0;
    end else if (bus.mem_stall_c) begin
      chg_q <= 1'b0;
    end else if (chg_q || !vld) begin
      npc_q <= 32'd0; alu_q <= 32'd0; b_q <= 32'd0; tgt_q <= 32'd0;
      dest_q <= 5'd0; wr_q <= 1'b0; chg_q <= 1'b0; op_q <= 6'd0; ty_q <= 2'd0;
    end else begin
      npc_q  <= bus.ID_EX_nextPC;
      alu_q  <= res;
      b_q    <= b_fwd;
      tgt_q  <= tgt;
      dest_q <= wr ? dst : 5'd0;
      wr_q   <= wr && (dst != 5'd0);
      chg_q  <= tkn;
      op_q   <= bus.ID_EX_op;
      ty_q   <= bus.ID_EX_instruc_type;
    end
  end

  assign bus.EX_MEM_nextPC       = npc_q;
  assign bus.EX_MEM_ALUout       = alu_q;
  assign bus.EX_MEM_B            = b_q;
  assign bus.EX_MEM_dest         = dest_q;
  assign bus.EX_MEM_regwrite     = wr_q;
  assign bus.EX_MEM_op           = op_q;
  assign bus.EX_MEM_instruc_type = ty_q;
  assign bus.EX_MEM_changePC_c   = chg_q;
  assign bus.EX_MEM_target       = tgt_q;
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed + randomized checks of the execute stage against an
// instruction-level reference model (expected EX_MEM contents per cycle,
// HI/LO from 64-bit signed arithmetic).
module tb_execute;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_if bus();
  execute dut (.clock(clk), .reset_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] npc, alu, b, tgt;
    logic [4:0]  dest;
    logic        wr, chg;
    logic [5:0]  op;
    logic [1:0]  ty;
    bit          c_alu, c_b, c_tgt, c_dest;
  } exp_t;

  int total = 0;
  int bad = 0;
  exp_t cur;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.npc = 0; e.alu = 0; e.b = 0; e.tgt = 0; e.dest = 0;
    e.wr = 0; e.chg = 0; e.op = 0; e.ty = 0;
    e.c_alu = 1; e.c_b = 1; e.c_tgt = 1; e.c_dest = 1;
    return e;
  endfunction

  // What EX_MEM should hold after executing one instruction
  function automatic exp_t model(logic [1:0] ty, logic [5:0] op, logic [31:0] npc,
                                 logic [31:0] a, logic [31:0] b, logic [15:0] imm,
                                 logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    exp_t e = bubble();
    logic [31:0] sx = {{16{imm[15]}}, imm};
    logic [31:0] r = 0;
    logic [4:0] d = 0;
    bit ok = 1, w = 0, taken = 0, store = 0;
    if (ty == 2'b11) begin
      d = rd; w = 1;
      case (op)
        6'b100000: r = a + b;
        6'b100010: r = a - b;
        6'b100100: r = a & b;
        6'b100101: r = a | b;
        6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'b000000: r = b << imm[10:6];
        6'b010000: r = hi_m;
        6'b010010: r = lo_m;
        default:   ok = 0;
      endcase
    end else if (ty == 2'b10) begin
      d = rt; w = 1;
      case (op)
        6'b001000: r = a + sx;
        6'b001010: r = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
        6'b001100: r = a & {16'd0, imm};
        6'b001101: r = a | {16'd0, imm};
        6'b100011: r = a + sx;
        6'b101011: begin r = a + sx; w = 0; store = 1; end
        6'b000100: begin w = 0; taken = (a == b); end
        6'b000101: begin w = 0; taken = (a != b); end
        default:   ok = 0;
      endcase
      if (taken) e.tgt = npc + (sx << 2);
    end else if (ty == 2'b01 && op == 6'b000010) begin
      taken = 1;
      e.tgt = {npc[31:28], rs, rt, imm, 2'b00};
    end else ok = 0;
    if (!ok) return bubble();
    e.npc = npc; e.op = op; e.ty = ty;
    e.chg = taken; e.c_tgt = taken;
    e.wr = w && (d != 0);
    e.c_dest = w; e.dest = d;
    e.c_alu = w || store; e.alu = r;
    e.c_b = store; e.b = b;
    return e;
  endfunction

`ifdef EX_FORWARD_EN
  function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] raw);
    if (r != 0 && cur.wr && cur.dest == r && !(cur.ty == 2'b10 && cur.op == 6'b100011))
      return cur.alu;
    if (r != 0 && bus.WB_WEenable && bus.WB_dest == r) return bus.WB_value;
    return raw;
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_exp(string tag, exp_t e);
    chk({tag, ".npc"}, bus.EX_MEM_nextPC, e.npc);
    chk({tag, ".ctl"}, {22'd0, bus.EX_MEM_op, bus.EX_MEM_instruc_type,
                        bus.EX_MEM_regwrite, bus.EX_MEM_changePC_c},
                       {22'd0, e.op, e.ty, e.wr, e.chg});
    if (e.c_dest) chk({tag, ".dest"}, {27'd0, bus.EX_MEM_dest}, {27'd0, e.dest});
    if (e.c_alu)  chk({tag, ".alu"}, bus.EX_MEM_ALUout, e.alu);
    if (e.c_b)    chk({tag, ".b"}, bus.EX_MEM_B, e.b);
    if (e.c_tgt)  chk({tag, ".tgt"}, bus.EX_MEM_target, e.tgt);
  endtask

  task automatic issue(string tag, logic [1:0] ty, logic [5:0] op, logic [31:0] npc,
                       logic [31:0] a, logic [31:0] b, logic [15:0] imm,
                       logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, bit ms);
    exp_t nxt;
    logic [31:0] ae = a, be = b;
    bus.ID_EX_instruc_type = ty; bus.ID_EX_op = op; bus.ID_EX_nextPC = npc;
    bus.ID_EX_A = a; bus.ID_EX_B = b; bus.ID_EX_imm = imm;
    bus.ID_EX_rs = rs; bus.ID_EX_rt = rt; bus.ID_EX_rd = rd;
    bus.mem_stall_c = ms;
`ifdef EX_FORWARD_EN
    ae = fwd(rs, a);
    be = fwd(rt, b);
`endif
    if (ms) begin nxt = cur; nxt.chg = 0; nxt.c_tgt = 0; end
    else if (cur.chg) nxt = bubble();
    else nxt = model(ty, op, npc, ae, be, imm, rs, rt, rd);
    step();
    chk_exp(tag, nxt);
    cur = nxt;
  endtask

  // Launch MULT/DIV, measure the stall, then read HI/LO back with MFHI/MFLO
  task automatic do_md(string tag, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                       output logic [31:0] hi_o, output logic [31:0] lo_o);
    int n = 0;
    int sa = a, sb = b;
    longint p;
    bus.ID_EX_instruc_type = 2'b11; bus.ID_EX_op = op; bus.ID_EX_nextPC = 32'h40;
    bus.ID_EX_A = a; bus.ID_EX_B = b; bus.ID_EX_imm = 0;
    bus.ID_EX_rs = 0; bus.ID_EX_rt = 0; bus.ID_EX_rd = 0; bus.mem_stall_c = 0;
    #1;
    while (bus.ex_stall_c && n < 100) begin n++; step(); end
    chk({tag, ".stall_cycles"}, n, 33);
    step();
    cur = bubble();
    chk_exp({tag, ".done_bubble"}, cur);
    if (op == 6'b011000) begin
      p = longint'($signed(a)) * longint'($signed(b));
      hi_m = p[63:32]; lo_m = p[31:0];
    end else if (b == 0) begin
      lo_m = 32'hFFFF_FFFF; hi_m = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo_m = 32'h8000_0000; hi_m = 0;
    end else begin
      lo_m = sa / sb; hi_m = sa % sb;
    end
    issue({tag, ".mfhi"}, 2'b11, 6'b010000, 32'h44, 0, 0, 0, 0, 0, 5'd5, 0);
    hi_o = bus.EX_MEM_ALUout;
    issue({tag, ".mflo"}, 2'b11, 6'b010010, 32'h48, 0, 0, 0, 0, 0, 5'd6, 0);
    lo_o = bus.EX_MEM_ALUout;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, a, b, npc;
    logic [1:0] ty;
    logic [5:0] op;
    cur = bubble();
    bus.mem_stall_c = 0; bus.ID_EX_nextPC = 0; bus.ID_EX_A = 0; bus.ID_EX_B = 0;
    bus.ID_EX_imm = 0; bus.ID_EX_rs = 0; bus.ID_EX_rt = 0; bus.ID_EX_rd = 0;
    bus.ID_EX_op = 0; bus.ID_EX_instruc_type = 0;
    bus.WB_WEenable = 0; bus.WB_dest = 0; bus.WB_value = 0;

    // reset state
    #1;
    chk_exp("reset", bubble());
    chk("reset.stall", {31'd0, bus.ex_stall_c}, 32'd0);
    step();
    rst_n = 1;

    // ADD then asynchronous reset mid-stream
    issue("add", 2'b11, 6'b100000, 32'h10, 32'd5, 32'd7, 0, 5'd8, 5'd9, 5'd3, 0);
    chk("add.alu12", bus.EX_MEM_ALUout, 32'd12);
    rst_n = 0;
    #1;
    chk_exp("async_rst", bubble());
    cur = bubble();
    rst_n = 1;

    // taken BEQ redirects and squashes the next entry
    issue("beq", 2'b10, 6'b000100, 32'h100, 32'd9, 32'd9, 16'h0004, 5'd1, 5'd2, 0, 0);
    chk("beq.target", bus.EX_MEM_target, 32'h110);
    issue("squash", 2'b11, 6'b100000, 32'h104, 32'd1, 32'd1, 0, 5'd8, 5'd9, 5'd4, 0);
    chk("squash.regwrite", {31'd0, bus.EX_MEM_regwrite}, 32'd0);

    // mem stall freezes EX_MEM for three cycles during ORI
    issue("pre_ori", 2'b11, 6'b100010, 32'h200, 32'd50, 32'd8, 0, 5'd8, 5'd9, 5'd7, 0);
    for (int i = 0; i < 3; i++)
      issue("ori_hold", 2'b10, 6'b001101, 32'h204, 32'h1234_0003, 0, 16'hFFF0, 5'd8, 5'd10, 0, 1);
    issue("ori", 2'b10, 6'b001101, 32'h204, 32'h1234_0003, 0, 16'hFFF0, 5'd8, 5'd10, 0, 0);
    chk("ori.alu", bus.EX_MEM_ALUout, 32'h1234_FFF3);

    // MULT / DIV directed cases
    do_md("mult", 6'b011000, -32'sd3, 32'h0001_0000, h, l);
    chk("mult.hi", h, 32'hFFFF_FFFF);
    chk("mult.lo", l, 32'hFFFD_0000);
    do_md("div", 6'b011010, -32'sd7, 32'd2, h, l);
    chk("div.hi", h, 32'hFFFF_FFFF);
    chk("div.lo", l, 32'hFFFF_FFFD);
    do_md("div0", 6'b011010, 32'd5, 32'd0, h, l);
    chk("div0.hi", h, 32'd5);
    chk("div0.lo", l, 32'hFFFF_FFFF);
    do_md("divmin", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    chk("divmin.lo", l, 32'h8000_0000);
    for (int i = 0; i < 5; i++)
      do_md("md_rnd", ($urandom_range(0, 1) != 0) ? 6'b011000 : 6'b011010, $urandom,
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, h, l);

    // randomized single-cycle traffic with occasional memory stalls
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 19))
        0:  begin ty = 2'b11; op = 6'b100000; end
        1:  begin ty = 2'b11; op = 6'b100010; end
        2:  begin ty = 2'b11; op = 6'b100100; end
        3:  begin ty = 2'b11; op = 6'b100101; end
        4:  begin ty = 2'b11; op = 6'b101010; end
        5:  begin ty = 2'b11; op = 6'b000000; end
        6:  begin ty = 2'b11; op = 6'b010000; end
        7:  begin ty = 2'b11; op = 6'b010010; end
        8:  begin ty = 2'b11; op = 6'b111111; end
        9:  begin ty = 2'b10; op = 6'b001000; end
        10: begin ty = 2'b10; op = 6'b001010; end
        11: begin ty = 2'b10; op = 6'b001100; end
        12: begin ty = 2'b10; op = 6'b001101; end
        13: begin ty = 2'b10; op = 6'b100011; end
        14: begin ty = 2'b10; op = 6'b101011; end
        15: begin ty = 2'b10; op = 6'b000100; end
        16: begin ty = 2'b10; op = 6'b000101; end
        17: begin ty = 2'b01; op = 6'b000010; end
        18: begin ty = 2'b00; op = 6'($urandom); end
        default: begin ty = 2'b10; op = 6'b111111; end
      endcase
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      npc = $urandom & 32'hFFFF_FFFC;
      issue("rnd", ty, op, npc, a, b, 16'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom_range(0, 5) == 0);
    end

    // reset during a MULT aborts it and clears HI/LO
    bus.ID_EX_instruc_type = 2'b11; bus.ID_EX_op = 6'b011000;
    bus.ID_EX_A = 32'd1234; bus.ID_EX_B = 32'd5678; bus.ID_EX_rs = 0; bus.ID_EX_rt = 0;
    bus.mem_stall_c = 0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 0;
    #1;
    chk_exp("md_rst", bubble());
    chk("md_rst.stall", {31'd0, bus.ex_stall_c}, 32'd1);
    rst_n = 1;
    cur = bubble(); hi_m = 0; lo_m = 0;
    issue("md_rst.mfhi", 2'b11, 6'b010000, 32'h60, 0, 0, 0, 0, 0, 5'd5, 0);
    issue("md_rst.mflo", 2'b11, 6'b010010, 32'h64, 0, 0, 0, 0, 0, 5'd6, 0);
    chk("md_rst.lo0", bus.EX_MEM_ALUout, 32'd0);

`ifdef EX_FORWARD_EN
    // back-to-back dependency: EX_MEM result wins over a matching WB
    issue("fw1", 2'b11, 6'b100000, 32'h80, 32'd2, 32'd3, 0, 5'd20, 5'd21, 5'd1, 0);
    bus.WB_WEenable = 1; bus.WB_dest = 5'd1; bus.WB_value = 32'd99;
    issue("fw2", 2'b11, 6'b100000, 32'h84, 32'd0, 32'd0, 0, 5'd1, 5'd1, 5'd2, 0);
    chk("fw2.alu10", bus.EX_MEM_ALUout, 32'd10);
    bus.WB_WEenable = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
